// File: rtl/count_sequencer.sv
// count_sequencer: command-driven controller for the up-counter datapath.
// It holds the count, a programmable terminal value and a clock prescaler.
// A host sends LOAD/START/PAUSE/STOP commands over a valid/ready port.
// Optional build macro COUNT_SEQUENCER_AUTO_RELOAD_EN: DONE returns to RUN
// with a cleared count, so the block counts periodically until STOP.
// Without the macro, DONE returns to IDLE and the count holds at terminal.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; LOAD sets the terminal value, START begins counting
// RUN   | prescaler running; count steps on each tick
// PAUSE | count and prescaler frozen; START resumes, STOP aborts
// DONE  | single cycle at terminal count; commands are not accepted here
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic [WIDTH-1:0] count_inc;
  logic             accept;
  logic             tick;

  // Outputs decode the registers only; nothing here looks at the command inputs.
  assign cmd_ready = (state_q != S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done      = (state_q == S_DONE);
  assign state     = state_q;
  assign count     = count_q;

  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (state_q == S_RUN) && (ps_q == PS_LAST);
  assign count_inc = count_q + WIDTH'(1);

  // State, count, terminal and prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= '1;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      ps_q    <= ps_d;
    end
  end

  // Next-state and datapath update; a legal command pre-empts a same-cycle tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    ps_d    = ps_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              term_d  = cmd_data;
              count_d = '0;
              ps_d    = '0;
            end
            OP_START: begin
              count_d = '0;
              ps_d    = '0;
              state_d = (term_q == '0) ? S_DONE : S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (accept && cmd_op == OP_START) begin
          count_d = '0;
          ps_d    = '0;
        end else if (accept && cmd_op == OP_PAUSE) begin
          state_d = S_PAUSE;
        end else if (accept && cmd_op == OP_STOP) begin
          count_d = '0;
          ps_d    = '0;
          state_d = S_IDLE;
        end else if (term_q == '0) begin
          // Only reachable by auto-reload with a zero terminal.
          state_d = S_DONE;
        end else if (tick) begin
          ps_d    = '0;
          count_d = count_inc;
          if (count_inc == term_q) state_d = S_DONE;
        end else begin
          ps_d = ps_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (accept && cmd_op == OP_START) begin
          state_d = S_RUN;
        end else if (accept && cmd_op == OP_STOP) begin
          count_d = '0;
          ps_d    = '0;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
        count_d = '0;
        ps_d    = '0;
        state_d = S_RUN;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer. Two instances (PRESCALE 1 and 3) share
// clock, reset and command op/data; each has its own cmd_valid. Expected
// outputs are queued when a step is driven and compared after the next edge.
module tb_count_sequencer;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] PSE   = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       v1, v3;
  logic       r1, r3, b1, b3, d1, d3;
  logic [3:0] c1, c3;
  logic [1:0] s1, s3;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .count(c1), .busy(b1), .done(d1), .state(s1)
  );

  count_sequencer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v3), .cmd_ready(r3),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .count(c3), .busy(b3), .done(d3), .state(s3)
  );

  typedef struct {
    string      tag;
    bit         sel;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Expected vector {state, count, done, busy, cmd_ready} from the state alone.
  function automatic logic [8:0] pack_exp(logic [1:0] st, logic [3:0] cnt);
    return {st, cnt, st == DONE, (st == RUN) || (st == PAUSE), st != DONE};
  endfunction

  function automatic logic [8:0] observe(bit sel);
    if (sel) return {s3, c3, d3, b3, r3};
    return {s1, c1, d1, b1, r1};
  endfunction

  task automatic push(string tag, bit sel, logic [1:0] st, logic [3:0] cnt);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = pack_exp(st, cnt);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [8:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_assert++;
      assert (o === e.exp) else begin
        n_fail++;
        $display("FAIL %s: observed st/cnt/done/busy/ready=%b expected %b", e.tag, o, e.exp);
        $error("%s observed %b expected %b", e.tag, o, e.exp);
      end
    end
  endtask

  // Drive one command (or none) for the next edge and check the result after it.
  task automatic cyc(string tag, bit sel, bit v, logic [1:0] op, logic [3:0] data,
                     logic [1:0] st, logic [3:0] cnt);
    if (sel) v3 = v;
    else     v1 = v;
    cmd_op   = op;
    cmd_data = data;
    push(tag, sel, st, cnt);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
    drain();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    v1       = 1'b0;
    v3       = 1'b0;
    cmd_op   = 2'b00;
    cmd_data = 4'd0;
    #2;
    push("rst_init1", 0, IDLE, 4'd0);
    push("rst_init3", 1, IDLE, 4'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
    cyc("a_load", 0, 1, LOAD, 4'd2, IDLE, 4'd0);
    cyc("a_start", 0, 1, START, 4'd0, RUN, 4'd0);
    for (int e = 1; e <= 7; e++)
      cyc($sformatf("a_run%0d", e), 0, 0, LOAD, 4'd0, (e % 3 == 2) ? DONE : RUN, 4'(e % 3));
    cyc("a_stop", 0, 1, STOP, 4'd0, IDLE, 4'd0);
    cyc("a_idle", 0, 0, LOAD, 4'd0, IDLE, 4'd0);
    cyc("a0_load", 0, 1, LOAD, 4'd0, IDLE, 4'd0);
    cyc("a0_start", 0, 1, START, 4'd0, DONE, 4'd0);
    cyc("a0_run1", 0, 0, LOAD, 4'd0, RUN, 4'd0);
    cyc("a0_done2", 0, 0, LOAD, 4'd0, DONE, 4'd0);
    cyc("a0_run3", 0, 0, LOAD, 4'd0, RUN, 4'd0);
    cyc("a0_stop", 0, 1, STOP, 4'd0, IDLE, 4'd0);
`else
    // Basic run, PRESCALE=1, terminal 5.
    cyc("b_load5", 0, 1, LOAD, 4'd5, IDLE, 4'd0);
    cyc("b_start", 0, 1, START, 4'd0, RUN, 4'd0);
    for (int k = 1; k <= 5; k++)
      cyc($sformatf("b_step%0d", k), 0, 0, LOAD, 4'd0, (k == 5) ? DONE : RUN, 4'(k));
    cyc("b_idle", 0, 0, LOAD, 4'd0, IDLE, 4'd5);
    cyc("b_hold", 0, 0, LOAD, 4'd0, IDLE, 4'd5);

    // Terminal 0: DONE right after START.
    cyc("z_load0", 0, 1, LOAD, 4'd0, IDLE, 4'd0);
    cyc("z_start", 0, 1, START, 4'd0, DONE, 4'd0);
    cyc("z_idle", 0, 0, LOAD, 4'd0, IDLE, 4'd0);

    // Terminal 15: reaches 15 without wrapping; valid held through DONE.
    cyc("m_load15", 0, 1, LOAD, 4'd15, IDLE, 4'd0);
    cyc("m_start", 0, 1, START, 4'd0, RUN, 4'd0);
    for (int k = 1; k <= 15; k++)
      cyc($sformatf("m_step%0d", k), 0, 0, LOAD, 4'd0, (k == 15) ? DONE : RUN, 4'(k));
    cyc("m_held_in_done", 0, 1, LOAD, 4'd3, IDLE, 4'd15);
    cyc("m_held_accepted", 0, 1, LOAD, 4'd3, IDLE, 4'd0);

    // STOP on the final tick wins; LOAD in RUN is dropped.
    cyc("c_start", 0, 1, START, 4'd0, RUN, 4'd0);
    cyc("c_step1", 0, 0, LOAD, 4'd0, RUN, 4'd1);
    cyc("c_step2", 0, 0, LOAD, 4'd0, RUN, 4'd2);
    cyc("c_stop", 0, 1, STOP, 4'd0, IDLE, 4'd0);
    cyc("c_nodone", 0, 0, LOAD, 4'd0, IDLE, 4'd0);
    cyc("c_start2", 0, 1, START, 4'd0, RUN, 4'd0);
    cyc("c_load7", 0, 1, LOAD, 4'd7, RUN, 4'd1);
    cyc("c_step2b", 0, 0, LOAD, 4'd0, RUN, 4'd2);
    cyc("c_done3", 0, 0, LOAD, 4'd0, DONE, 4'd3);
    cyc("c_idle", 0, 0, LOAD, 4'd0, IDLE, 4'd3);

    // Restart in RUN clears the count.
    cyc("s_start", 0, 1, START, 4'd0, RUN, 4'd0);
    cyc("s_step1", 0, 0, LOAD, 4'd0, RUN, 4'd1);
    cyc("s_restart", 0, 1, START, 4'd0, RUN, 4'd0);
    cyc("s_stop", 0, 1, STOP, 4'd0, IDLE, 4'd0);

    // Pause/resume, PRESCALE=3, terminal 4; pause with count 2, prescaler 1.
    cyc("p_load4", 1, 1, LOAD, 4'd4, IDLE, 4'd0);
    cyc("p_start", 1, 1, START, 4'd0, RUN, 4'd0);
    for (int e = 1; e <= 7; e++)
      cyc($sformatf("p_run%0d", e), 1, 0, LOAD, 4'd0, RUN, 4'(e / 3));
    cyc("p_pause", 1, 1, PSE, 4'd0, PAUSE, 4'd2);
    for (int e = 9; e <= 17; e++)
      cyc($sformatf("p_hold%0d", e), 1, (e == 12), PSE, 4'd0, PAUSE, 4'd2);
    cyc("p_resume", 1, 1, START, 4'd0, RUN, 4'd2);
    for (int e = 19; e <= 23; e++)
      cyc($sformatf("p_after%0d", e), 1, 0, LOAD, 4'd0, (e == 23) ? DONE : RUN, 4'((e - 11) / 3));
    cyc("p_idle", 1, 0, LOAD, 4'd0, IDLE, 4'd4);
    cyc("p2_start", 1, 1, START, 4'd0, RUN, 4'd0);
    cyc("p2_pause", 1, 1, PSE, 4'd0, PAUSE, 4'd0);
    cyc("p2_load_drop", 1, 1, LOAD, 4'd9, PAUSE, 4'd0);
    cyc("p2_stop", 1, 1, STOP, 4'd0, IDLE, 4'd0);

    // Asynchronous reset mid-run at count 5, then terminal reads back as 15.
    cyc("r_load9", 0, 1, LOAD, 4'd9, IDLE, 4'd0);
    cyc("r_start", 0, 1, START, 4'd0, RUN, 4'd0);
    for (int k = 1; k <= 5; k++)
      cyc($sformatf("r_step%0d", k), 0, 0, LOAD, 4'd0, RUN, 4'(k));
    #3;
    rst_n = 1'b0;
    #1;
    push("r_async", 0, IDLE, 4'd0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("r_start15", 0, 1, START, 4'd0, RUN, 4'd0);
    for (int k = 1; k <= 15; k++)
      cyc($sformatf("r_term%0d", k), 0, 0, LOAD, 4'd0, (k == 15) ? DONE : RUN, 4'(k));
    cyc("r_idle", 0, 0, LOAD, 4'd0, IDLE, 4'd15);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven controller for the lab's up-counter datapath. It holds the counter, a programmable terminal value and a clock prescaler, and sequences them through load, start, pause, stop and terminal-count phases. A host, such as the button/switch front end or a test FSM, issues commands over a valid/ready port. The block reports progress on `count`, `busy` and a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4: width of `count`, `cmd_data` and the terminal register.
- `PRESCALE`, 1: clk cycles per count step; legal range ≥1.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op` input 2: 00 LOAD, 01 START, 10 PAUSE, 11 STOP.
- `cmd_data` input WIDTH: terminal value, used by LOAD only.
- `count` output WIDTH: current count.
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: high for exactly the one cycle spent in DONE.
- `state` output 2: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- **Reset values:**
  - state IDLE, `count`=0, terminal={WIDTH{1}} (15 at WIDTH=4), prescaler=0.
  - `done`=0, `busy`=0, `cmd_ready`=1.
- **cmd_ready:** 1 in every state except DONE. Commands that are accepted but illegal in the current state are dropped with no side effects.
- **tick:** defined as `state==RUN && prescaler==PRESCALE-1`.
  - The prescaler counts 0..PRESCALE-1 in RUN and wraps to 0 on tick.
  - It freezes in PAUSE and clears on START-from-IDLE, on STOP and on reload.
- **IDLE:**
  - LOAD: terminal←`cmd_data`, `count`←0.
  - START: `count`←0, prescaler←0, go to RUN. If terminal==0, go directly to DONE instead.
  - PAUSE and STOP are dropped.
- **RUN:**
  - On tick: `count`←`count`+1. If `count`+1==terminal, go to DONE.
  - PAUSE: go to PAUSE, holding `count` and prescaler.
  - STOP: `count`←0, go to IDLE.
  - START: restart with `count`←0 and prescaler←0; stay in RUN.
  - LOAD: dropped. Terminal never changes while busy.
  - If an accepted command and a tick occur in the same cycle, the command wins and the tick is discarded.
- **PAUSE:**
  - START: resume in RUN with `count` and prescaler preserved.
  - STOP: `count`←0, go to IDLE.
  - LOAD and PAUSE: dropped.
- **DONE:** lasts one cycle; `count` holds the terminal value. On the next edge, go to IDLE with `count` held (see Configuration for the alternative).
- **Arithmetic:** `count` is unsigned WIDTH bits and never exceeds terminal, so it never wraps. The maximum run is (2^WIDTH−1)·PRESCALE cycles.
- **Reset mid-operation:** asynchronous return to the reset values listed above. Terminal is also reset.

## Timing
- A command accepted at edge N takes effect in registers at edge N; `state`, `busy` and `count` reflect it in the following cycle.
- **Start to done latency:** with START accepted at edge N, terminal T≥1 and no further commands:
  - `count` steps at edges N+k·PRESCALE, for k=1..T.
  - `count`==T and `done`=1 during the cycle after edge N+T·PRESCALE.
  - IDLE is entered at edge N+T·PRESCALE+1.
- **START with terminal 0:** `done` is high in the cycle after edge N.
- **Back-to-back commands:** commands are accepted every cycle except the DONE cycle. A held `cmd_valid` is therefore stalled exactly one cycle by DONE.
- **Outputs:** all outputs are registered or decoded from the state register only. There are no combinational paths from the command inputs to any output.

## Configuration
- **`COUNT_SEQUENCER_AUTO_RELOAD_EN` defined:** DONE → RUN with `count`←0 and prescaler←0, so counting is periodic with a `done` pulse every T·PRESCALE+1 cycles. STOP is the only way back to IDLE.
  - With terminal 0 in this mode, the block alternates between RUN and DONE; `done` is high every second cycle.
- **Macro undefined:** DONE → IDLE with `count` held at terminal, as described in Operation.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with `count`=5 → `count`=0, `state`=00, `done`=0 and `cmd_ready`=1 without waiting for a clock edge; terminal reads back as 15 via START, giving `done` after 15 steps.
- **Basic run:** PRESCALE=1, LOAD 5, START at edge N → `count` 1..5 at edges N+1..N+5; `done`=1 in exactly one cycle; IDLE at N+6 with `count`=5.
- **Pause/resume:** PRESCALE=3, LOAD 4, START, PAUSE at `count`=2 with prescaler=1, hold 10 cycles, then START → `count` is frozen during PAUSE; `done` arrives exactly 10+1 cycles later than in an uninterrupted run.
- **Command/tick collision:** STOP coincides with the tick that would make `count`=3 of 3 → no `done` pulse; IDLE with `count`=0. LOAD 7 while in RUN → dropped; terminal stays 3.
- **Edge values:** LOAD 0, START → `done` high in the next cycle with `count`=0. LOAD 15 at WIDTH=4 → `count` reaches 15 with no wrap. `cmd_valid` held during DONE → `cmd_ready`=0 for that cycle only.
- **Auto-reload (macro on):** LOAD 2, START, PRESCALE=1 → `done` pulses every 3 cycles and `count` cycles 1,2,0,1,2…; STOP → IDLE.
